fwd_hazard_unit: RTL and testbench

Parametrised forwarding and load-use interlock unit for the RISC-V pipeline, successor to the fixed two-source EX/MEM–MEM/WB forwarding logic. It keeps its own shadow of the instructions in EX and the post-EX stages. From that shadow it produces:
- per-operand bypass selects for the EX stage;
- a load-use stall/bubble for the ID stage;
- a saturating stall-cycle performance counter.

Depth, source count and load latency are parameters.

---
 rtl/fwd_hazard_unit_pkg.sv | 24 ++
 rtl/fwd_hazard_unit_if.sv | 34 +++
 rtl/fwd_hazard_unit_track_stage.sv | 19 +
 rtl/fwd_hazard_unit.sv | 111 +++++++++++
 tb/tb_fwd_hazard_unit.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/fwd_hazard_unit_pkg.sv
// Shared types and helpers for the forwarding / load-use interlock unit.
// The shadow entry carries a fixed-width rd so one struct serves any REG_ADDR_W up to TRACK_RD_W.
package fwd_pkg;

   localparam int TRACK_RD_W = 8;
   localparam int FWD_SEL_RF = 0;

   typedef struct packed {
      logic                  valid;
      logic [TRACK_RD_W-1:0] rd;
      logic                  regwrite;
      logic                  is_load;
   } track_entry_t;

   function automatic int sel_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   // x0 is hardwired to zero, so it never produces a value worth bypassing.
   function automatic logic is_writer(input track_entry_t e);
      return e.valid && e.regwrite && (e.rd != '0);
   endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// ID-stage request bundle and EX-stage bypass/stall response of the hazard unit.
interface fwd_hazard_unit_if
   import fwd_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter int NUM_SRC    = 2,
   parameter int FWD_DEPTH  = 2,
   parameter int CNT_W      = 16
) ();

   localparam int SEL_W = sel_w(FWD_DEPTH);

   logic                          id_valid;
   logic [NUM_SRC*REG_ADDR_W-1:0] id_rs;
   logic [NUM_SRC-1:0]            id_rs_used;
   logic [REG_ADDR_W-1:0]         id_rd;
   logic                          id_regwrite;
   logic                          id_is_load;
   logic                          flush;
   logic [NUM_SRC*SEL_W-1:0]      fwd_sel;
   logic                          stall;
   logic [CNT_W-1:0]              stall_count;

   modport master (
      output id_valid, id_rs, id_rs_used, id_rd, id_regwrite, id_is_load, flush,
      input  fwd_sel, stall, stall_count
   );

   modport slave (
      input  id_valid, id_rs, id_rs_used, id_rd, id_regwrite, id_is_load, flush,
      output fwd_sel, stall, stall_count
   );

endinterface

// File: rtl/fwd_hazard_unit_track_stage.sv
// One post-EX shadow entry; chained so that entry j holds what was in EX j cycles ago.
module fwd_track_stage
   import fwd_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  track_entry_t d,
   output track_entry_t q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else begin
         q <= d;
      end
   end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use interlock built from a private shadow of EX and post-EX stages.
// Bypass selects depend only on registered state; the stall looks at the live ID request.
module fwd_hazard_unit
   import fwd_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter int NUM_SRC    = 2,
   parameter int FWD_DEPTH  = 2,
   parameter int LOAD_LAT   = 1,
   parameter int CNT_W      = 16
) (
   input logic         clk,
   input logic         rst_n,
   fwd_hazard_unit_if.slave bus
);

   localparam int SEL_W = sel_w(FWD_DEPTH);

   track_entry_t                  s [0:FWD_DEPTH];
   track_entry_t                  ex_entry;
   logic [NUM_SRC*REG_ADDR_W-1:0] ex_rs;
   logic [NUM_SRC-1:0]            ex_rs_used;
   logic                          load_hit;
   logic                          stall;
   logic [CNT_W-1:0]              stall_count;

   function automatic logic [TRACK_RD_W-1:0] widen(input logic [REG_ADDR_W-1:0] r);
      return TRACK_RD_W'(r);
   endfunction

   // EX entry: killed, held-back or empty ID slots all enter EX as a bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_entry   <= '0;
         ex_rs      <= '0;
         ex_rs_used <= '0;
      end else if (stall || bus.flush || !bus.id_valid) begin
         ex_entry   <= '0;
         ex_rs      <= '0;
         ex_rs_used <= '0;
      end else begin
         ex_entry.valid    <= 1'b1;
         ex_entry.rd       <= widen(bus.id_rd);
         ex_entry.regwrite <= bus.id_regwrite;
         ex_entry.is_load  <= bus.id_is_load;
         ex_rs             <= bus.id_rs;
         ex_rs_used        <= bus.id_rs_used;
      end
   end

   assign s[0] = ex_entry;

   for (genvar j = 1; j <= FWD_DEPTH; j++) begin : g_stage
      fwd_track_stage u_stage (
         .clk   (clk),
         .rst_n (rst_n),
         .d     (s[j-1]),
         .q     (s[j])
      );
   end

   always_comb begin
      load_hit = 1'b0;
      for (int k = 0; k < NUM_SRC; k++) begin
         for (int j = 0; j < LOAD_LAT; j++) begin
            if (bus.id_rs_used[k] && is_writer(s[j]) && s[j].is_load &&
                (s[j].rd == widen(bus.id_rs[k*REG_ADDR_W +: REG_ADDR_W]))) begin
               load_hit = 1'b1;
            end
         end
      end
   end

   // A flushed instruction never needs its operands, so flush overrides the interlock.
   assign stall     = load_hit && bus.id_valid && !bus.flush;
   assign bus.stall = stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_count <= '0;
      end else if (stall && (stall_count != '1)) begin
         stall_count <= stall_count + CNT_W'(1);
      end
   end

   assign bus.stall_count = stall_count;

   for (genvar k = 0; k < NUM_SRC; k++) begin : g_operand
      logic [FWD_DEPTH:1] hit;
      logic [SEL_W-1:0]   sel;

      for (genvar j = 1; j <= FWD_DEPTH; j++) begin : g_hit
         assign hit[j] = ex_rs_used[k] && is_writer(s[j]) &&
                         (s[j].rd == widen(ex_rs[k*REG_ADDR_W +: REG_ADDR_W])) &&
                         (!s[j].is_load || (j > LOAD_LAT));
      end

      // Scan from the oldest stage down so the youngest match is written last.
      always_comb begin
         sel = SEL_W'(FWD_SEL_RF);
         for (int j = FWD_DEPTH; j >= 1; j--) begin
            if (hit[j]) begin
               sel = SEL_W'(j);
            end
         end
      end

      assign bus.fwd_sel[k*SEL_W +: SEL_W] = sel;
   end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: default pipeline instance plus a deeper, narrow-counter instance.
module tb_fwd_hazard_unit;
   import fwd_pkg::*;

   logic clk;
   logic rst_n;
   int   compared   = 0;
   int   mismatched = 0;

   fwd_hazard_unit_if #(.REG_ADDR_W(5), .NUM_SRC(2), .FWD_DEPTH(2), .CNT_W(16)) bus ();
   fwd_hazard_unit_if #(.REG_ADDR_W(5), .NUM_SRC(2), .FWD_DEPTH(3), .CNT_W(4))  small_bus ();

   fwd_hazard_unit #(
      .REG_ADDR_W (5), .NUM_SRC (2), .FWD_DEPTH (2), .LOAD_LAT (1), .CNT_W (16)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   fwd_hazard_unit #(
      .REG_ADDR_W (5), .NUM_SRC (2), .FWD_DEPTH (3), .LOAD_LAT (2), .CNT_W (4)
   ) u_small (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (small_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // A load sitting in stage 1 must never be the bypass source while LOAD_LAT is 1.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int k = 0; k < 2; k++) begin
            if (bus.fwd_sel[k*2 +: 2] == 2'd1) begin
               assert (!u_dut.s[1].is_load)
                  else $error("[TB] load in stage 1 selected for operand %0d", k);
            end
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [1:0] used, input logic [4:0] rd, input logic rw,
                                input logic ld, input logic fl);
      bus.id_valid    = v;
      bus.id_rs       = {rs2, rs1};
      bus.id_rs_used  = used;
      bus.id_rd       = rd;
      bus.id_regwrite = rw;
      bus.id_is_load  = ld;
      bus.flush       = fl;
      #1;
   endtask

   task automatic applySmall(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [1:0] used, input logic [4:0] rd, input logic rw,
                             input logic ld, input logic fl);
      small_bus.id_valid    = v;
      small_bus.id_rs       = {rs2, rs1};
      small_bus.id_rs_used  = used;
      small_bus.id_rd       = rd;
      small_bus.id_regwrite = rw;
      small_bus.id_is_load  = ld;
      small_bus.flush       = fl;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      applyStimulus(0, 0, 0, 2'b00, 0, 0, 0, 0);
      repeat (3) tick();
   endtask

   initial begin
      rst_n = 1'b0;
      applyStimulus(0, 0, 0, 2'b00, 0, 0, 0, 0);
      applySmall(0, 0, 0, 2'b00, 0, 0, 0, 0);
      checkOutput("reset_stall", {31'd0, bus.stall}, 32'd0);
      checkOutput("reset_fwd_sel", {28'd0, bus.fwd_sel}, 32'd0);
      checkOutput("reset_count", {16'd0, bus.stall_count}, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // ALU result forwarded from EX/MEM, then from MEM/WB with a spacer
      applyStimulus(1, 0, 0, 2'b00, 5, 1, 0, 0);
      tick();
      applyStimulus(1, 5, 0, 2'b01, 6, 1, 0, 0);
      checkOutput("alu_no_stall", {31'd0, bus.stall}, 32'd0);
      tick();
      checkOutput("fwd_stage1", {28'd0, bus.fwd_sel}, 32'h1);
      applyStimulus(1, 0, 0, 2'b00, 5, 1, 0, 0);
      tick();
      applyStimulus(1, 0, 0, 2'b00, 9, 1, 0, 0);
      tick();
      applyStimulus(1, 5, 0, 2'b01, 10, 1, 0, 0);
      tick();
      checkOutput("fwd_stage2", {28'd0, bus.fwd_sel}, 32'h2);
      drain();

      // Two writers of x7: the younger one wins
      applyStimulus(1, 0, 0, 2'b00, 7, 1, 0, 0);
      tick();
      applyStimulus(1, 0, 0, 2'b00, 7, 1, 0, 0);
      tick();
      applyStimulus(1, 0, 7, 2'b10, 11, 1, 0, 0);
      tick();
      checkOutput("youngest_wins_rs2", {28'd0, bus.fwd_sel}, 32'h4);
      applyStimulus(1, 0, 0, 2'b00, 7, 1, 0, 0);
      tick();
      applyStimulus(1, 7, 7, 2'b11, 13, 1, 0, 0);
      tick();
      checkOutput("both_operands_x7", {28'd0, bus.fwd_sel}, 32'h5);
      drain();

      // Load-use: one stall, bubble into EX, then bypass from MEM/WB
      applyStimulus(1, 0, 0, 2'b00, 3, 1, 1, 0);
      tick();
      applyStimulus(1, 3, 4, 2'b11, 12, 1, 0, 0);
      checkOutput("load_use_stall", {31'd0, bus.stall}, 32'd1);
      tick();
      checkOutput("load_use_released", {31'd0, bus.stall}, 32'd0);
      checkOutput("load_use_count", {16'd0, bus.stall_count}, 32'd1);
      checkOutput("load_use_bubble_sel", {28'd0, bus.fwd_sel}, 32'h0);
      tick();
      checkOutput("load_use_fwd", {28'd0, bus.fwd_sel}, 32'h2);
      checkOutput("load_use_count_hold", {16'd0, bus.stall_count}, 32'd1);
      drain();

      applyStimulus(1, 0, 0, 2'b00, 3, 1, 1, 0);
      tick();
      applyStimulus(1, 0, 0, 2'b00, 9, 1, 0, 0);
      tick();
      applyStimulus(1, 3, 0, 2'b01, 14, 1, 0, 0);
      checkOutput("load_gap_no_stall", {31'd0, bus.stall}, 32'd0);
      tick();
      checkOutput("load_gap_fwd", {28'd0, bus.fwd_sel}, 32'h2);
      drain();

      // Unused operand and x0 never interlock or bypass
      applyStimulus(1, 0, 0, 2'b00, 3, 1, 1, 0);
      tick();
      applyStimulus(1, 3, 3, 2'b00, 15, 1, 0, 0);
      checkOutput("unused_rs_no_stall", {31'd0, bus.stall}, 32'd0);
      drain();
      applyStimulus(1, 0, 0, 2'b00, 0, 1, 0, 0);
      tick();
      applyStimulus(1, 0, 0, 2'b11, 16, 1, 0, 0);
      tick();
      checkOutput("x0_no_fwd", {28'd0, bus.fwd_sel}, 32'h0);
      drain();
      applyStimulus(1, 0, 0, 2'b00, 0, 1, 1, 0);
      tick();
      applyStimulus(1, 0, 0, 2'b11, 16, 1, 0, 0);
      checkOutput("x0_load_no_stall", {31'd0, bus.stall}, 32'd0);
      drain();

      // Flush beats a pending load-use stall and kills the ID instruction
      applyStimulus(1, 0, 0, 2'b00, 3, 1, 1, 0);
      tick();
      applyStimulus(1, 3, 0, 2'b01, 12, 1, 0, 1);
      checkOutput("flush_beats_stall", {31'd0, bus.stall}, 32'd0);
      tick();
      checkOutput("flush_count_same", {16'd0, bus.stall_count}, 32'd1);
      applyStimulus(1, 12, 0, 2'b01, 14, 1, 0, 0);
      tick();
      checkOutput("flush_killed_ex", {28'd0, bus.fwd_sel}, 32'h0);
      drain();

      // Reset mid-stream with three writers in flight
      applyStimulus(1, 0, 0, 2'b00, 20, 1, 0, 0);
      tick();
      applyStimulus(1, 0, 0, 2'b00, 21, 1, 0, 0);
      tick();
      applyStimulus(1, 21, 20, 2'b11, 22, 1, 0, 0);
      tick();
      checkOutput("pre_reset_fwd", {28'd0, bus.fwd_sel}, 32'h9);
      rst_n = 1'b0;
      #1;
      checkOutput("midreset_fwd_sel", {28'd0, bus.fwd_sel}, 32'h0);
      checkOutput("midreset_stall", {31'd0, bus.stall}, 32'd0);
      checkOutput("midreset_count", {16'd0, bus.stall_count}, 32'd0);
      tick();
      rst_n = 1'b1;
      applyStimulus(1, 21, 20, 2'b11, 23, 1, 0, 0);
      tick();
      checkOutput("post_reset_fwd", {28'd0, bus.fwd_sel}, 32'h0);
      drain();

      // Deeper instance: two-cycle load interlock, bypass from stage 3, 4-bit counter saturation
      applySmall(1, 0, 0, 2'b00, 3, 1, 1, 0);
      tick();
      applySmall(1, 3, 0, 2'b01, 3, 1, 1, 0);
      checkOutput("small_stall_a", {31'd0, small_bus.stall}, 32'd1);
      tick();
      checkOutput("small_stall_b", {31'd0, small_bus.stall}, 32'd1);
      checkOutput("small_count_1", {28'd0, small_bus.stall_count}, 32'd1);
      tick();
      checkOutput("small_release", {31'd0, small_bus.stall}, 32'd0);
      checkOutput("small_count_2", {28'd0, small_bus.stall_count}, 32'd2);
      tick();
      checkOutput("small_fwd_stage3", {28'd0, small_bus.fwd_sel}, 32'h3);
      checkOutput("small_restall", {31'd0, small_bus.stall}, 32'd1);
      repeat (30) tick();
      checkOutput("small_count_sat", {28'd0, small_bus.stall_count}, 32'hF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
